// File: rtl/pong_ctrl.sv
// vPong game-logic controller: bar and ball motion, bounces, scoring.
// All motion advances on frame_tick; start acts on any clock.
module pong_ctrl #(
  parameter int COLS     = 128,
  parameter int ROWS     = 96,
  parameter int BAR_ROW  = 90,
  parameter int BAR_W    = 6,
  parameter int BALL_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       start,
  output logic [6:0] ball_x,
  output logic [6:0] ball_y,
  output logic [6:0] bar_x,
  output logic [6:0] bar_y,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int DW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;

  localparam logic [6:0] BAR_C   = 7'((COLS - BAR_W) / 2);
  localparam logic [6:0] BAR_MAX = 7'(COLS - BAR_W);
  localparam logic [6:0] HALF    = 7'(BAR_W / 2);
  localparam logic [6:0] X_MAX   = 7'(COLS - 1);
  localparam logic [6:0] Y_MAX   = 7'(ROWS - 1);
  localparam logic [6:0] ROW_A   = 7'(BAR_ROW - 1);
  localparam logic [6:0] ROW_B   = 7'(BAR_ROW - 2);
  localparam logic [DW-1:0] DIV_TOP = DW'(BALL_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  state_t        state, state_nx;
  logic [6:0]    bar_x_nx, ball_x_nx, ball_y_nx;
  logic          dx, dy, dx_nx, dy_nx;
  logic [7:0]    score_nx;
  logic [DW-1:0] div, div_nx;

  logic [6:0] bar_mv;
  logic [7:0] bar_end;
  logic       on_bar;
  logic [6:0] step_x, step_y;
  logic       step_dx, step_dy;
  logic       hit, miss;

  // dx/dy: 1 means +1, 0 means -1
  always_comb begin
    bar_mv = bar_x;
    if (btn_left && !btn_right && bar_x != 7'd0)
      bar_mv = bar_x - 7'd1;
    else if (btn_right && !btn_left && bar_x < BAR_MAX)
      bar_mv = bar_x + 7'd1;
  end

  assign bar_end = {1'b0, bar_x} + 8'(BAR_W - 1);
  assign on_bar  = ({1'b0, ball_x} >= {1'b0, bar_x})
                && ({1'b0, ball_x} <= bar_end);

  always_comb begin
    step_x  = ball_x;
    step_dx = dx;
    if (ball_x == 7'd0 && !dx) begin
      step_x  = 7'd1;
      step_dx = 1'b1;
    end else if (ball_x == X_MAX && dx) begin
      step_x  = X_MAX - 7'd1;
      step_dx = 1'b0;
    end else begin
      step_x = dx ? ball_x + 7'd1 : ball_x - 7'd1;
    end
  end

  always_comb begin
    step_y  = ball_y;
    step_dy = dy;
    hit     = 1'b0;
    miss    = 1'b0;
    if (ball_y == 7'd0 && !dy) begin
      step_y  = 7'd1;
      step_dy = 1'b1;
    end else if (ball_y == ROW_A && dy && on_bar) begin
      step_y  = ROW_B;
      step_dy = 1'b0;
      hit     = 1'b1;
    end else if (ball_y == Y_MAX && dy) begin
      miss = 1'b1;
    end else begin
      step_y = dy ? ball_y + 7'd1 : ball_y - 7'd1;
    end
  end

  always_comb begin
    state_nx  = state;
    bar_x_nx  = bar_x;
    ball_x_nx = ball_x;
    ball_y_nx = ball_y;
    dx_nx     = dx;
    dy_nx     = dy;
    score_nx  = score;
    div_nx    = div;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          bar_x_nx  = bar_mv;
          ball_x_nx = bar_mv + HALF;
          ball_y_nx = ROW_A;
        end
        if (start) begin
          state_nx = PLAY;
          dx_nx    = 1'b1;
          dy_nx    = 1'b0;
          div_nx   = '0;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          bar_x_nx = bar_mv;
          if (div == DIV_TOP) begin
            div_nx = '0;
            if (miss) begin
              state_nx = OVER;
            end else begin
              ball_x_nx = step_x;
              dx_nx     = step_dx;
              ball_y_nx = step_y;
              dy_nx     = step_dy;
            end
            if (hit) score_nx = score + 8'd1;
          end else begin
            div_nx = div + DW'(1);
          end
        end
      end
      OVER: begin
        if (start) begin
          state_nx  = IDLE;
          score_nx  = 8'd0;
          bar_x_nx  = BAR_C;
          ball_x_nx = BAR_C + HALF;
          ball_y_nx = ROW_A;
          dx_nx     = 1'b1;
          dy_nx     = 1'b0;
          div_nx    = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bar_x  <= BAR_C;
      ball_x <= BAR_C + HALF;
      ball_y <= ROW_A;
      dx     <= 1'b1;
      dy     <= 1'b0;
      score  <= 8'd0;
      div    <= '0;
    end else begin
      state  <= state_nx;
      bar_x  <= bar_x_nx;
      ball_x <= ball_x_nx;
      ball_y <= ball_y_nx;
      dx     <= dx_nx;
      dy     <= dy_nx;
      score  <= score_nx;
      div    <= div_nx;
    end
  end

  assign bar_y     = 7'(BAR_ROW);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl: bar clamp, serve, wall/corner bounce,
// bar hit edges, miss to game over, restart and mid-game reset.
module tb_pong_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       start = 1'b0;
  logic [6:0] ball_x, ball_y, bar_x, bar_y;
  logic [7:0] score;
  logic       game_over;

  int n_assert = 0;
  int n_fail = 0;

  pong_ctrl dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .start(start),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .bar_x(bar_x),
    .bar_y(bar_y),
    .score(score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(ball_x), 32'(x));
    chk({tag, ".y"}, 32'(ball_y), 32'(y));
  endtask

  // Serve from centre, hold left for lefts ticks, run to tick total.
  task automatic run_play(input int lefts, input int total);
    do_reset();
    pulse_start();
    btn_left = 1'b1;
    tick(lefts);
    btn_left = 1'b0;
    tick(total - lefts);
  endtask

  initial begin
    do_reset();
    chk("rst.bar_x", 32'(bar_x), 61);
    chk_ball("rst", 64, 89);
    chk("rst.score", 32'(score), 0);
    chk("rst.go", 32'(game_over), 0);
    chk("rst.bar_y", 32'(bar_y), 90);

    tick(3);
    chk("idle3.bar_x", 32'(bar_x), 61);
    chk_ball("idle3", 64, 89);
    chk("idle3.go", 32'(game_over), 0);

    btn_left = 1'b1;
    tick(70);
    btn_left = 1'b0;
    chk("left.bar_x", 32'(bar_x), 0);
    chk_ball("left", 3, 89);

    btn_right = 1'b1;
    tick(130);
    chk("right.bar_x", 32'(bar_x), 122);
    chk_ball("right", 125, 89);

    btn_left = 1'b1;
    tick(2);
    btn_left = 1'b0;
    btn_right = 1'b0;
    chk("both.bar_x", 32'(bar_x), 122);

    // serve, then let the ball miss the centred bar
    do_reset();
    pulse_start();
    chk_ball("serve0", 64, 89);
    tick(1);
    chk_ball("serve1", 64, 89);
    tick(1);
    chk_ball("serve2", 65, 88);
    tick(2);
    chk_ball("serve4", 66, 87);
    tick(122);
    chk_ball("rwall_pre", 127, 26);
    tick(2);
    chk_ball("rwall", 126, 25);
    tick(50);
    chk_ball("top_pre", 101, 0);
    tick(2);
    chk_ball("top", 100, 1);
    tick(176);
    chk_ball("row89", 12, 89);
    tick(12);
    chk_ball("row95", 6, 95);
    chk("row95.go", 32'(game_over), 0);
    tick(2);
    chk("miss.go", 32'(game_over), 1);
    chk_ball("miss", 6, 95);
    chk("miss.score", 32'(score), 0);
    btn_left = 1'b1;
    tick(4);
    btn_left = 1'b0;
    chk("over.bar_x", 32'(bar_x), 61);
    chk_ball("over", 6, 95);
    chk("over.go", 32'(game_over), 1);
    pulse_start();
    chk("restart.go", 32'(game_over), 0);
    chk("restart.score", 32'(score), 0);
    chk("restart.bar_x", 32'(bar_x), 61);
    chk_ball("restart", 64, 89);

    // bar_x=12: ball x=12 on left edge hits, then left wall
    run_play(49, 356);
    chk("hitL.bar_x", 32'(bar_x), 12);
    chk_ball("hitL.pre", 12, 89);
    tick(1);
    tick(1);
    chk_ball("hitL", 11, 88);
    chk("hitL.score", 32'(score), 1);
    tick(22);
    chk_ball("lwall_pre", 0, 77);
    tick(2);
    chk_ball("lwall", 1, 76);
    tick(2);
    chk_ball("lwall2", 2, 75);

    // bar_x=7: ball x=12 on right edge hits
    run_play(54, 358);
    chk_ball("hitR", 11, 88);
    chk("hitR.score", 32'(score), 1);

    // bar_x=13 and bar_x=6: just outside, both miss
    run_play(48, 358);
    chk_ball("missL", 11, 90);
    chk("missL.score", 32'(score), 0);
    run_play(55, 358);
    chk_ball("missR", 11, 90);
    chk("missR.score", 32'(score), 0);

    // top-right corner: serve from ball_x=38
    do_reset();
    btn_left = 1'b1;
    tick(26);
    btn_left = 1'b0;
    chk_ball("corner.serve", 38, 89);
    pulse_start();
    tick(178);
    chk_ball("corner.pre", 127, 0);
    tick(2);
    chk_ball("corner", 126, 1);
    tick(2);
    chk_ball("corner2", 125, 2);

    // mid-play reset overrides a simultaneous tick
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b1;
    btn_right = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    btn_right = 1'b0;
    chk("mrst.bar_x", 32'(bar_x), 61);
    chk_ball("mrst", 64, 89);
    chk("mrst.go", 32'(game_over), 0);
    tick(2);
    chk_ball("mrst.idle", 64, 89);

    // start together with a tick: tracking applied, then play
    @(negedge clk);
    start = 1'b1;
    frame_tick = 1'b1;
    btn_left = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0;
    chk("st_tk.bar_x", 32'(bar_x), 60);
    chk_ball("st_tk", 63, 89);
    tick(1);
    chk_ball("st_tk1", 63, 89);
    tick(1);
    chk_ball("st_tk2", 64, 88);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ctrl.md
Name: pong_ctrl

Overview:
- Game-logic controller for the vPong playfield. It owns the ball and bar positions and sequences their motion once per video frame.
- Outputs are in 5-pixel grid cells (7-bit x_place/y_place) and feed the Ball and Bar renderers directly.
- Handles wall and bar bounces, miss detection, scoring, and the serve/play/game-over sequence.

Parameters:
- COLS, 128, playfield width in cells (640 px / 5).
- ROWS, 96, playfield height in cells (480 px / 5).
- BAR_ROW, 90, fixed cell row of the bar.
- BAR_W, 6, bar width in cells (30 px).
- BALL_DIV, 2, frame ticks per ball step (1 = one step per frame).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high; one clock, reset sampled on rising clk.
- frame_tick  in  1  one-clk pulse per frame (start of vertical blank).
- btn_left  in  1  level; move bar left.
- btn_right  in  1  level; move bar right.
- start  in  1  level/pulse; serve from IDLE, restart from OVER.
- ball_x  out  7  ball column (cell).
- ball_y  out  7  ball row (cell).
- bar_x  out  7  bar left column (cell).
- bar_y  out  7  constant BAR_ROW.
- score  out  8  bar hits since last restart, wraps 255->0.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE, bar_x=(COLS-BAR_W)/2=61, ball_x=bar_x+BAR_W/2=64, ball_y=BAR_ROW-1=89, dx=+1, dy=-1, score=0, game_over=0, ball divider=0. Reset overrides every other input in that cycle.
- All updates happen on the clk edge where frame_tick=1. Outputs are registered, so new values are visible the cycle after the tick. No other cycle changes positions.
- Start is the only input acted on without a tick.

Bar motion (IDLE and PLAY, on tick):
- left only: bar_x-1, clamped at 0.
- right only: bar_x+1, clamped at COLS-BAR_W=122.
- both or neither: hold.
- Bar is frozen in OVER.

IDLE:
- Ball tracks the bar: ball_x = new bar_x + BAR_W/2, ball_y = BAR_ROW-1, same edge as the bar move.
- start=1 -> PLAY next edge: dx=+1, dy=-1, divider=0, position unchanged. If start and frame_tick are high in the same cycle, the bar/ball tracking is applied and the state also goes to PLAY.

PLAY:
- Divider counts ticks 0..BALL_DIV-1. A ball step occurs on the tick where divider==BALL_DIV-1, then divider returns to 0.
- All step decisions use the pre-step ball and the pre-tick bar_x.
- X axis:
  - x==0 and dx=-1: dx=+1, x=1.
  - x==COLS-1 and dx=+1: dx=-1, x=COLS-2.
  - otherwise x+=dx.
- Y axis, priority order:
  1. y==0 and dy=-1: dy=+1, y=1.
  2. y==BAR_ROW-1 and dy=+1 and bar_x <= x <= bar_x+BAR_W-1 (pre-step x): dy=-1, y=BAR_ROW-2, score+1.
  3. y==ROWS-1 and dy=+1: state=OVER, ball holds at ROWS-1, no x update.
  4. otherwise y+=dy.
- Corner hits flip dx and dy in the same step.
- A ball below BAR_ROW-1 that misses the bar continues downward and never re-tests the bar.

OVER:
- game_over=1; ball and bar hold.
- start=1 -> IDLE next edge with score=0 and bar/ball re-centred to reset values; game_over drops that same edge.

Widths and intermediates:
- Edge tests use compares on 7-bit values. No intermediate may wrap below 0 or above COLS-1/ROWS-1.
- bar_x+BAR_W-1 is computed at 8 bits.
- Mid-game reset returns to the reset state immediately with no residual motion.

Test Plan:
- Reset, no buttons, 3 ticks -> bar_x=61, ball=(64,89), score=0, game_over=0, state IDLE throughout.
- Hold btn_left in IDLE for 70 ticks -> bar_x reaches 0 and stays 0, ball_x=3. Hold btn_right 130 ticks -> bar_x=122, ball_x=125. Both buttons -> bar_x unchanged.
- start, BALL_DIV=2, 4 ticks from (64,89) -> ball steps on ticks 2 and 4: (65,88), then (66,87).
- Wall/corner: force ball (1,1) with dx=-1, dy=-1, BALL_DIV=1 -> after 1 tick (0,0); after the next tick (1,1) with dx=+1, dy=+1. Right wall at x=127, dx=+1 -> x=126, dx=-1.
- Bar hit: ball (70,89) dy=+1, bar_x=66 -> next step y=88, dy=-1, score=1. Edge cases: x=66 and x=71 hit; x=65 and x=72 miss.
- Miss: ball passes row 89 outside the bar -> reaches row 95, then next step game_over=1, positions frozen, buttons ignored. start -> IDLE, score=0, bar_x=61, ball=(64,89). Reset asserted mid-PLAY gives the same reset values next edge.
